// File: rtl/animation_scheduler_pkg.sv
// Shared types and default timing constants for the animation frame sequencer.
package animation_scheduler_pkg;

    localparam int unsigned PHASE_W                = 8;
    localparam int unsigned STEP_W                 = 3;
    localparam int unsigned DEF_NUM_PATTERNS       = 4;
    localparam int unsigned DEF_PAT_W              = 2;
    localparam int unsigned DEF_FRAMES_PER_PATTERN = 240;
    localparam int unsigned DEF_FADE_FRAMES        = 16;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_FADE = 1'b1
    } state_e;

endpackage

// File: rtl/edge_detect_rise.sv
// One-bit rising-edge detector; the pulse is combinational from the registered previous sample.
module edge_detect_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_c_o
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_c_o = d_i & ~d_q;

endmodule

// File: rtl/animation_scheduler.sv
// Frame sequencer: gates vsync edges into frame ticks, advances the phase and rotates patterns through a fade.
module animation_scheduler
    import animation_scheduler_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS       = DEF_NUM_PATTERNS,
    parameter int unsigned PAT_W              = DEF_PAT_W,
    parameter int unsigned FRAMES_PER_PATTERN = DEF_FRAMES_PER_PATTERN,
    parameter int unsigned FADE_FRAMES        = DEF_FADE_FRAMES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               paused,
    input  logic [STEP_W-1:0]  step_size,
    input  logic               step_req,
    input  logic               auto_cycle,
    output logic               frame_tick,
    output logic [PHASE_W-1:0] phase,
    output logic [PAT_W-1:0]   pattern_sel,
    output logic               fade_active,
    output logic [PHASE_W-1:0] fade_level
);

    localparam int unsigned CNT_W = $clog2(FRAMES_PER_PATTERN);

    logic               vs_rise_c;
    logic               step_pending_q, step_pending_d;
    logic               frame_tick_q, frame_tick_d;
    logic [PHASE_W-1:0] phase_q;
    logic [PAT_W-1:0]   pattern_sel_q;
    logic               fade_active_q;
    logic [PHASE_W-1:0] fade_level_q;
    logic [CNT_W-1:0]   frame_cnt_q;
    state_e             state_q;

    edge_detect_rise u_vsync_rise (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_i      (vsync),
        .rise_c_o (vs_rise_c)
    );

    // A pending step is consumed by the next edge; a request coincident with an edge waits for the following one.
    always_comb begin
        step_pending_d = 1'b0;
        frame_tick_d   = vs_rise_c & (~paused | step_pending_q);
        if (paused) begin
            step_pending_d = (step_pending_q & ~vs_rise_c) | step_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_pending_q <= 1'b0;
            frame_tick_q   <= 1'b0;
        end else begin
            step_pending_q <= step_pending_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    // Per-frame sequencing: run/fade state machine, all updates qualified by the registered tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            phase_q       <= '0;
            pattern_sel_q <= '0;
            fade_active_q <= 1'b0;
            fade_level_q  <= '0;
            frame_cnt_q   <= '0;
        end else if (frame_tick_q) begin
            phase_q <= phase_q + PHASE_W'(step_size);
            case (state_q)
                S_RUN: begin
                    if (!auto_cycle) begin
                        frame_cnt_q <= '0;
                    end else if (frame_cnt_q == CNT_W'(FRAMES_PER_PATTERN - 1)) begin
                        state_q       <= S_FADE;
                        frame_cnt_q   <= '0;
                        fade_level_q  <= '0;
                        fade_active_q <= 1'b1;
                    end else begin
                        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                    end
                end
                S_FADE: begin
                    if (fade_level_q == PHASE_W'(FADE_FRAMES - 1)) begin
                        state_q       <= S_RUN;
                        fade_active_q <= 1'b0;
                        fade_level_q  <= '0;
                        phase_q       <= '0;
                        if (pattern_sel_q == PAT_W'(NUM_PATTERNS - 1)) begin
                            pattern_sel_q <= '0;
                        end else begin
                            pattern_sel_q <= pattern_sel_q + PAT_W'(1);
                        end
                    end else begin
                        fade_level_q <= fade_level_q + PHASE_W'(1);
                    end
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign frame_tick  = frame_tick_q;
    assign phase       = phase_q;
    assign pattern_sel = pattern_sel_q;
    assign fade_active = fade_active_q;
    assign fade_level  = fade_level_q;

endmodule

// File: tb/tb_animation_scheduler.sv
// Directed bench for animation_scheduler with a frame-level reference model checked every cycle.
module tb_animation_scheduler;

    localparam int unsigned NP   = 3;
    localparam int unsigned PW   = 2;
    localparam int unsigned FPP  = 4;
    localparam int unsigned FADE = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vsync;
    logic          paused;
    logic [2:0]    step_size;
    logic          step_req;
    logic          auto_cycle;
    logic          frame_tick;
    logic [7:0]    phase;
    logic [PW-1:0] pattern_sel;
    logic          fade_active;
    logic [7:0]    fade_level;

    int n_checks = 0;
    int n_pass   = 0;
    int tick_cnt = 0;

    animation_scheduler #(
        .NUM_PATTERNS       (NP),
        .PAT_W              (PW),
        .FRAMES_PER_PATTERN (FPP),
        .FADE_FRAMES        (FADE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .paused      (paused),
        .step_size   (step_size),
        .step_req    (step_req),
        .auto_cycle  (auto_cycle),
        .frame_tick  (frame_tick),
        .phase       (phase),
        .pattern_sel (pattern_sel),
        .fade_active (fade_active),
        .fade_level  (fade_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    endtask

    // Reference model: frames, run counts and fade progress tracked as plain integers.
    int m_phase, m_pat, m_fade, m_run_frames;
    bit m_fading, m_tick, m_pend, m_vs_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_pat <= 0; m_fade <= 0; m_run_frames <= 0;
            m_fading <= 0; m_tick <= 0; m_pend <= 0; m_vs_prev <= 0;
        end else begin
            if (m_tick) begin
                if (m_fading) begin
                    if (m_fade + 1 == int'(FADE)) begin
                        m_fading <= 0; m_fade <= 0; m_phase <= 0;
                        m_pat <= (m_pat + 1) % int'(NP);
                    end else begin
                        m_fade  <= m_fade + 1;
                        m_phase <= (m_phase + int'(step_size)) % 256;
                    end
                end else begin
                    m_phase <= (m_phase + int'(step_size)) % 256;
                    if (auto_cycle && m_run_frames + 1 == int'(FPP)) begin
                        m_fading <= 1; m_fade <= 0; m_run_frames <= 0;
                    end else begin
                        m_run_frames <= auto_cycle ? m_run_frames + 1 : 0;
                    end
                end
            end
            m_tick    <= (vsync && !m_vs_prev) && (!paused || m_pend);
            m_pend    <= paused && ((m_pend && !(vsync && !m_vs_prev)) || step_req);
            m_vs_prev <= vsync;
        end
    end

    always @(negedge clk) begin
        chk("frame_tick", int'(frame_tick), int'(m_tick));
        chk("phase", int'(phase), m_phase);
        chk("pattern_sel", int'(pattern_sel), m_pat);
        chk("fade_active", int'(fade_active), int'(m_fading));
        chk("fade_level", int'(fade_level), m_fade);
        if (frame_tick) tick_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        wait_cyc(1);
        vsync = 1'b0;
        wait_cyc(3);
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) vs_pulse();
    endtask

    task automatic pulse_step();
        step_req = 1'b1;
        wait_cyc(1);
        step_req = 1'b0;
        wait_cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_n = 1'b0; vsync = 1'b0; paused = 1'b0; step_size = 3'd3;
        step_req = 1'b0; auto_cycle = 1'b0;
        #1;
        chk("reset_phase", int'(phase), 0);
        chk("reset_tick", int'(frame_tick), 0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);

        // Basic ticking and held vsync
        t0 = tick_cnt;
        for (int k = 1; k <= 4; k++) begin
            vs_pulse();
            chk("phase_step3", int'(phase), 3 * k);
        end
        chk("ticks_four", tick_cnt - t0, 4);
        t0 = tick_cnt;
        vsync = 1'b1;
        wait_cyc(100);
        vsync = 1'b0;
        wait_cyc(3);
        chk("ticks_held_vsync", tick_cnt - t0, 1);
        chk("phase_held", int'(phase), 15);

        // Phase wrap
        step_size = 3'd6;
        vs_pulses(39);
        step_size = 3'd5;
        vs_pulse();
        chk("phase_254", int'(phase), 254);
        vs_pulse();
        chk("phase_wrap", int'(phase), 3);

        // Pause and single stepping
        paused = 1'b1;
        t0 = tick_cnt;
        vs_pulses(3);
        chk("paused_no_ticks", tick_cnt - t0, 0);
        chk("paused_phase", int'(phase), 3);
        pulse_step();
        t0 = tick_cnt;
        vs_pulses(2);
        chk("single_step", tick_cnt - t0, 1);
        chk("step_phase", int'(phase), 8);
        pulse_step();
        pulse_step();
        t0 = tick_cnt;
        vs_pulses(2);
        chk("double_req_one_tick", tick_cnt - t0, 1);
        chk("double_req_phase", int'(phase), 13);
        paused = 1'b0;
        wait_cyc(1);
        pulse_step();
        paused = 1'b1;
        wait_cyc(1);
        t0 = tick_cnt;
        vs_pulse();
        chk("unpaused_req_ignored", tick_cnt - t0, 0);
        t0 = tick_cnt;
        vsync = 1'b1; step_req = 1'b1;
        wait_cyc(1);
        vsync = 1'b0; step_req = 1'b0;
        wait_cyc(3);
        chk("coincident_req_waits", tick_cnt - t0, 0);
        vs_pulse();
        chk("coincident_req_next", tick_cnt - t0, 1);
        chk("coincident_phase", int'(phase), 18);
        paused = 1'b0;
        wait_cyc(1);

        // Auto cycle with fade
        step_size = 3'd1;
        auto_cycle = 1'b1;
        vs_pulses(4);
        chk("fade_start", int'(fade_active), 1);
        chk("fade_start_phase", int'(phase), 22);
        vs_pulse();
        chk("fade_level_1", int'(fade_level), 1);
        vs_pulse();
        chk("pattern_1", int'(pattern_sel), 1);
        chk("phase_reset", int'(phase), 0);
        chk("fade_done", int'(fade_active), 0);
        vs_pulses(6);
        chk("pattern_2", int'(pattern_sel), 2);
        vs_pulses(6);
        chk("pattern_wrap", int'(pattern_sel), 0);

        // Drop auto_cycle mid-fade
        vs_pulses(4);
        chk("fade_again", int'(fade_active), 1);
        auto_cycle = 1'b0;
        vs_pulses(2);
        chk("fade_completes_pat", int'(pattern_sel), 1);
        chk("fade_completes_off", int'(fade_active), 0);
        vs_pulses(10);
        chk("no_more_fade", int'(fade_active), 0);
        chk("manual_phase", int'(phase), 10);

        // Async reset mid-fade
        auto_cycle = 1'b1;
        vs_pulses(5);
        chk("pre_reset_level", int'(fade_level), 1);
        chk("pre_reset_phase", int'(phase), 15);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_phase", int'(phase), 0);
        chk("rst_pattern", int'(pattern_sel), 0);
        chk("rst_fade_active", int'(fade_active), 0);
        chk("rst_fade_level", int'(fade_level), 0);
        chk("rst_tick", int'(frame_tick), 0);
        wait_cyc(2);
        rst_n = 1'b1;
        t0 = tick_cnt;
        wait_cyc(20);
        chk("no_tick_after_reset", tick_cnt - t0, 0);
        vs_pulse();
        chk("tick_after_edge", tick_cnt - t0, 1);
        chk("phase_after_reset", int'(phase), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
